q15_div_sequencer: RTL

Q15_DIV_SEQUENCER -- requirements
Module: q15_div_sequencer

---
 rtl/q15_div_sequencer_pkg.sv | 17 +
 rtl/q15_result_fifo.sv | 51 +++++
 rtl/q15_div_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/q15_div_sequencer_pkg.sv
// Shared Q15 definitions for the divide sequencer: data width, special values
// and the sequencer state encoding.
package q15_div_sequencer_pkg;

    localparam int Q15_DATA_W = 64;

    localparam logic [Q15_DATA_W-1:0] Q15_NAN = 64'h8000_0000_0000_0000;
    localparam logic [Q15_DATA_W-1:0] Q15_ONE = 64'h0000_0000_0000_8000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_SETTLE = 2'd2,
        ST_WAIT   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/q15_result_fifo.sv
// Two-entry result FIFO; the head entry is always presented on the output.
module q15_result_fifo #(
    parameter int ENTRY_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               valid,
    output logic [ENTRY_W-1:0] head
);

    logic [ENTRY_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == 2'd2);
    assign valid   = (count != 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/q15_div_sequencer.sv
// Sequences one request at a time through an external Q15 divider and queues
// tagged results (or timeout markers) in a two-entry FIFO.
//
// state  | meaning
// IDLE   | waiting for a request while the result FIFO has space
// LAUNCH | one-cycle launch pulse to the divider
// SETTLE | divider status not yet valid, ignored for one cycle
// WAIT   | waiting for div_busy low or timeout, then capture
module q15_div_sequencer
    import q15_div_sequencer_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Q15_DATA_W-1:0] in_a,
    input  logic [Q15_DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  div_launch,
    output logic [Q15_DATA_W-1:0] div_a,
    output logic [Q15_DATA_W-1:0] div_b,
    input  logic                  div_busy,
    input  logic [Q15_DATA_W-1:0] div_res,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Q15_DATA_W-1:0] out_res,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_timeout
);

    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam int ENTRY_W = Q15_DATA_W + TAG_W + 1;

    seq_state_t            state;
    seq_state_t            state_nxt;
    logic [Q15_DATA_W-1:0] op_a;
    logic [Q15_DATA_W-1:0] op_b;
    logic [TAG_W-1:0]      op_tag;
    logic [CNT_W-1:0]      wait_cnt;
    logic [CNT_W-1:0]      wait_nxt;
    logic                  accept;
    logic                  push;
    logic [Q15_DATA_W-1:0] push_res;
    logic                  push_to;
    logic                  fifo_full;
    logic [ENTRY_W-1:0]    fifo_head;

    // Gated by reset directly so in_ready is low while reset is held and
    // high in the very first cycle after release.
    assign in_ready = reset && (state == ST_IDLE) && !fifo_full;
    assign div_a    = op_a;
    assign div_b    = op_b;

    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        accept     = 1'b0;
        push       = 1'b0;
        push_res   = div_res;
        push_to    = 1'b0;
        div_launch = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    wait_nxt  = CNT_W'(TIMEOUT);
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                div_launch = 1'b1;
                state_nxt  = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!div_busy) begin
                    if (!fifo_full) begin
                        push      = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (wait_cnt <= CNT_W'(1)) begin
                    // terminal count: this is the TIMEOUT-th busy cycle
                    push_res = Q15_NAN;
                    push_to  = 1'b1;
                    if (!fifo_full) begin
                        push      = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    wait_nxt = wait_cnt - CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_tag   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (accept) begin
                op_a   <= in_a;
                op_b   <= in_b;
                op_tag <= in_tag;
            end
        end
    end

    q15_result_fifo #(
        .ENTRY_W (ENTRY_W)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({push_res, op_tag, push_to}),
        .pop       (out_ready),
        .full      (fifo_full),
        .valid     (out_valid),
        .head      (fifo_head)
    );

    assign {out_res, out_tag, out_timeout} = fifo_head;

endmodule
